// File: rtl/mtr_ctrl_pkg.sv
// Shared types and constants for the motor sequencing controller.
package mtr_ctrl_pkg;

   localparam int DRV_W = 12;

   localparam logic [2:0] HALL_BAD_LO = 3'b000;
   localparam logic [2:0] HALL_BAD_HI = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BRAKE = 2'd2,
      FAULT = 2'd3
   } mtr_state_t;

   function automatic logic hall_bad(input logic [2:0] code);
      return (code == HALL_BAD_LO) || (code == HALL_BAD_HI);
   endfunction

endpackage

// File: rtl/hall_debounce.sv
// 2-FF synchronizer plus 3-bit debouncer: a new code must be stable for
// DEBOUNCE consecutive cycles before it replaces the accepted code.
module hall_debounce
   import mtr_ctrl_pkg::*;
#(
   parameter int DEBOUNCE = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] hall_raw,
   output logic [2:0] hall_q,
   output logic       hall_vld,
   output logic       hall_chg
);

   localparam int CW = $clog2(DEBOUNCE + 1);

   logic [2:0]    sync1, sync2, cand;
   logic [CW-1:0] cnt, cnt_inc;
   logic          accept;

   // A differing code that is not the current candidate restarts the count at 1.
   assign cnt_inc = (sync2 == cand && cnt != '0) ? cnt + CW'(1) : CW'(1);
   assign accept  = (sync2 != hall_q) && (cnt_inc >= CW'(DEBOUNCE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= '0;
         sync2    <= '0;
         cand     <= '0;
         cnt      <= '0;
         hall_q   <= '0;
         hall_vld <= 1'b0;
         hall_chg <= 1'b0;
      end else begin
         sync1    <= hall_raw;
         sync2    <= sync1;
         hall_chg <= 1'b0;
         if (sync2 == hall_q) begin
            cnt <= '0;
         end else if (accept) begin
            hall_q   <= sync2;
            hall_vld <= 1'b1;
            hall_chg <= 1'b1;
            cnt      <= '0;
         end else begin
            cand <= sync2;
            cnt  <= cnt_inc;
         end
      end
   end

endmodule

// File: rtl/mtr_seq_ctrl.sv
// Motor sequencing controller: hall debounce, torque slew limiting and
// run/brake/fault supervision. Stall detection is built only with MTR_STALL_DET_EN.
module mtr_seq_ctrl
   import mtr_ctrl_pkg::*;
#(
   parameter int               RAMP_DIV      = 64,
   parameter logic [DRV_W-1:0] RAMP_STEP     = 12'd16,
   parameter int               DEBOUNCE      = 8,
   parameter int               STALL_TIMEOUT = 1048576,
   parameter logic [DRV_W-1:0] STALL_MIN     = 12'h100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hallGrn,
   input  logic             hallYlw,
   input  logic             hallBlu,
   input  logic             enable,
   input  logic [DRV_W-1:0] torque_req,
   input  logic             brake_req_n,
   output logic             hallGrn_q,
   output logic             hallYlw_q,
   output logic             hallBlu_q,
   output logic [DRV_W-1:0] drv_mag,
   output logic             brake_n,
   output logic             hall_err,
   output logic             stall
);

   localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   mtr_state_t       state, state_nxt;
   logic [2:0]       hall_code;
   logic             hall_vld;
   logic [RW-1:0]    tick_cnt;
   logic             tick;
   logic [DRV_W-1:0] target, ramp_nxt, drv_nxt;
   logic [DRV_W:0]   up_sum;
`ifdef MTR_STALL_DET_EN
   logic             hall_chg;
`endif

   hall_debounce #(.DEBOUNCE(DEBOUNCE)) u_hall (
      .clk      (clk),
      .rst_n    (rst_n),
      .hall_raw ({hallGrn, hallYlw, hallBlu}),
      .hall_q   (hall_code),
      .hall_vld (hall_vld),
`ifdef MTR_STALL_DET_EN
      .hall_chg (hall_chg)
`else
      .hall_chg ()
`endif
   );

   assign {hallGrn_q, hallYlw_q, hallBlu_q} = hall_code;
   // Masked until a real code has been accepted, so the reset value 000 is not an error.
   assign hall_err = hall_vld & hall_bad(hall_code);

   assign tick = (tick_cnt == RW'(RAMP_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tick_cnt <= '0;
      else        tick_cnt <= tick ? '0 : tick_cnt + RW'(1);
   end

   // Slew toward target at 13 bits going up; the down path never crosses target or 0.
   assign target = enable ? torque_req : '0;
   assign up_sum = {1'b0, drv_mag} + {1'b0, RAMP_STEP};

   always_comb begin
      ramp_nxt = drv_mag;
      if (drv_mag < target)
         ramp_nxt = (up_sum > {1'b0, target}) ? target : up_sum[DRV_W-1:0];
      else if (drv_mag > target)
         ramp_nxt = ((drv_mag - target) <= RAMP_STEP) ? target : drv_mag - RAMP_STEP;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (hall_err)                        state_nxt = FAULT;
                else if (enable && brake_req_n)      state_nxt = RUN;
         RUN:   if (hall_err || stall)               state_nxt = FAULT;
                else if (!brake_req_n)               state_nxt = BRAKE;
                else if (!enable && drv_mag == '0)   state_nxt = IDLE;
         BRAKE: if (brake_req_n)                     state_nxt = IDLE;
         FAULT: if (!enable && !hall_err)            state_nxt = IDLE;
         default:                                    state_nxt = IDLE;
      endcase
   end

   // Leaving RUN drops drive on the same edge; no ramp-down.
   always_comb begin
      drv_nxt = '0;
      if (state == RUN && state_nxt == RUN)
         drv_nxt = tick ? ramp_nxt : drv_mag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         drv_mag <= '0;
         brake_n <= 1'b1;
      end else begin
         state   <= state_nxt;
         drv_mag <= drv_nxt;
         brake_n <= (state_nxt != BRAKE);
      end
   end

`ifdef MTR_STALL_DET_EN
   localparam int SW = $clog2(STALL_TIMEOUT + 1);

   logic [SW-1:0] stall_cnt;
   logic          stall_r;
   logic          stall_arm;

   assign stall_arm = (state == RUN) && !hall_chg && (drv_mag >= STALL_MIN);
   assign stall     = stall_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         stall_r   <= 1'b0;
      end else begin
         if (state != RUN || hall_chg)
            stall_cnt <= '0;
         else if (stall_arm && !stall_r)
            stall_cnt <= stall_cnt + SW'(1);

         if (state == FAULT && state_nxt == IDLE)
            stall_r <= 1'b0;
         else if (stall_arm && stall_cnt == SW'(STALL_TIMEOUT - 1))
            stall_r <= 1'b1;
      end
   end
`else
   assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_mtr_seq_ctrl.sv
// Self-checking bench for mtr_seq_ctrl: vector table with scoreboard plus
// hand sequences for debounce timing, brake/fault priority, reset and stall.
module tb_mtr_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hallGrn, hallYlw, hallBlu;
   logic        enable;
   logic [11:0] torque_req;
   logic        brake_req_n;
   logic        hallGrn_q, hallYlw_q, hallBlu_q;
   logic [11:0] drv_mag;
   logic        brake_n, hall_err, stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mtr_seq_ctrl #(
      .RAMP_DIV      (4),
      .RAMP_STEP     (12'd16),
      .DEBOUNCE      (8),
      .STALL_TIMEOUT (1000),
      .STALL_MIN     (12'h100)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hallGrn     (hallGrn),
      .hallYlw     (hallYlw),
      .hallBlu     (hallBlu),
      .enable      (enable),
      .torque_req  (torque_req),
      .brake_req_n (brake_req_n),
      .hallGrn_q   (hallGrn_q),
      .hallYlw_q   (hallYlw_q),
      .hallBlu_q   (hallBlu_q),
      .drv_mag     (drv_mag),
      .brake_n     (brake_n),
      .hall_err    (hall_err),
      .stall       (stall)
   );

   typedef struct {
      logic        en;
      logic [11:0] tq;
      logic        brk_n;
      logic [2:0]  hall;
      int          wait_cyc;
      logic [11:0] exp_drv;
      logic        exp_bn;
      logic        exp_err;
      string       name;
   } vec_t;

   typedef struct {
      logic [11:0] drv;
      logic        bn;
      logic        err;
      string       name;
   } exp_t;

   vec_t vt[11];
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_hall(input logic [2:0] c);
      {hallGrn, hallYlw, hallBlu} = c;
   endtask

   task automatic apply_vec(input int i);
      exp_t e;
      enable      = vt[i].en;
      torque_req  = vt[i].tq;
      brake_req_n = vt[i].brk_n;
      set_hall(vt[i].hall);
      sb.push_back('{vt[i].exp_drv, vt[i].exp_bn, vt[i].exp_err, vt[i].name});
      step(vt[i].wait_cyc);
      e = sb.pop_front();
      check({e.name, "_drv"}, drv_mag, e.drv);
      check({e.name, "_brake_n"}, brake_n, e.bn);
      check({e.name, "_hall_err"}, hall_err, e.err);
   endtask

   initial begin
      logic [11:0] prev;
      int          nchg, last, cnt;
      bit          seen;

      vt[0]  = '{1'b1, 12'h005, 1'b1, 3'b100, 60, 12'h005, 1'b1, 1'b0, "ramp_down"};
      vt[1]  = '{1'b1, 12'h080, 1'b1, 3'b100, 60, 12'h080, 1'b1, 1'b0, "ramp_80"};
      vt[2]  = '{1'b1, 12'h080, 1'b0, 3'b100,  1, 12'h000, 1'b0, 1'b0, "brake_edge"};
      vt[3]  = '{1'b1, 12'h080, 1'b1, 3'b100,  1, 12'h000, 1'b1, 1'b0, "brake_release"};
      vt[4]  = '{1'b1, 12'h080, 1'b1, 3'b100, 60, 12'h080, 1'b1, 1'b0, "rerun_80"};
      vt[5]  = '{1'b0, 12'h080, 1'b1, 3'b100, 60, 12'h000, 1'b1, 1'b0, "disable_idle"};
      vt[6]  = '{1'b1, 12'h080, 1'b1, 3'b100, 60, 12'h080, 1'b1, 1'b0, "run_80"};
      vt[7]  = '{1'b1, 12'h080, 1'b1, 3'b111, 12, 12'h000, 1'b1, 1'b1, "hall_fault"};
      vt[8]  = '{1'b1, 12'h080, 1'b1, 3'b111, 20, 12'h000, 1'b1, 1'b1, "fault_hold"};
      vt[9]  = '{1'b0, 12'h080, 1'b1, 3'b011, 12, 12'h000, 1'b1, 1'b0, "fault_clear"};
      vt[10] = '{1'b1, 12'h080, 1'b1, 3'b011, 60, 12'h080, 1'b1, 1'b0, "post_fault_run"};

      rst_n = 1'b0; enable = 1'b0; torque_req = '0; brake_req_n = 1'b1;
      set_hall(3'b101);
      #22;
      check("rst_drv", drv_mag, 12'h000);
      check("rst_brake_n", brake_n, 1'b1);
      check("rst_stall", stall, 1'b0);
      check("rst_hall_err", hall_err, 1'b0);
      check("rst_hall_q", {hallGrn_q, hallYlw_q, hallBlu_q}, 3'b000);

      @(negedge clk) rst_n = 1'b1;
      step(20);
      check("accept_101", {hallGrn_q, hallYlw_q, hallBlu_q}, 3'b101);
      check("accept_err", hall_err, 1'b0);

      // Short glitch rejected; a held change lands exactly DEBOUNCE+1 edges after first sample.
      set_hall(3'b100); step(3); set_hall(3'b101); step(15);
      check("glitch_reject", {hallGrn_q, hallYlw_q, hallBlu_q}, 3'b101);
      set_hall(3'b100); step(9);
      check("deb_early", {hallGrn_q, hallYlw_q, hallBlu_q}, 3'b101);
      step(1);
      check("deb_exact", {hallGrn_q, hallYlw_q, hallBlu_q}, 3'b100);

      enable = 1'b1; torque_req = 12'h0C0;
      prev = '0; nchg = 0; last = 0;
      for (int i = 0; i < 80; i++) begin
         step(1);
         if (drv_mag !== prev) begin
            check("ramp_step", drv_mag, prev + 12'd16);
            if (nchg > 0) check("ramp_gap", i - last, 4);
            nchg++; last = i; prev = drv_mag;
         end
         check("ramp_cap", drv_mag <= 12'h0C0, 1'b1);
      end
      check("ramp_changes", nchg, 12);
      check("ramp_final", drv_mag, 12'h0C0);

      for (int i = 0; i <= 3; i++) apply_vec(i);

      // After brake release the next run starts from zero.
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1);
         if (drv_mag != 12'h000) seen = 1'b1;
      end
      check("restart_seen", seen, 1'b1);
      check("restart_first", drv_mag, 12'h010);

      for (int i = 4; i <= 10; i++) apply_vec(i);

      // Hall error and brake request on the same edge: fault must win.
      set_hall(3'b111); step(10);
      check("sim_err_seen", hall_err, 1'b1);
      check("sim_pre_drv", drv_mag, 12'h080);
      brake_req_n = 1'b0; step(1);
      check("sim_fault_brake_n", brake_n, 1'b1);
      check("sim_fault_drv", drv_mag, 12'h000);
      brake_req_n = 1'b1; enable = 1'b0; set_hall(3'b011); step(15);
      check("sim_recover_err", hall_err, 1'b0);
      check("sim_recover_drv", drv_mag, 12'h000);

      // Asynchronous reset mid-ramp.
      enable = 1'b1; torque_req = 12'h0C0; step(20);
      check("midramp_nonzero", drv_mag != 12'h000, 1'b1);
      #2 rst_n = 1'b0; #1;
      check("async_rst_drv", drv_mag, 12'h000);
      check("async_rst_brake_n", brake_n, 1'b1);
      check("async_rst_hall_q", {hallGrn_q, hallYlw_q, hallBlu_q}, 3'b000);
      @(negedge clk) rst_n = 1'b1;
      step(100);
      check("post_rst_ramp", drv_mag, 12'h0C0);

`ifdef MTR_STALL_DET_EN
      torque_req = 12'h200;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         step(1);
         if (drv_mag >= 12'h100) seen = 1'b1;
      end
      check("stall_armed", seen, 1'b1);
      cnt = 0;
      for (int i = 0; i < 1100 && !stall; i++) begin
         step(1);
         cnt++;
      end
      check("stall_cycle", cnt, 1000);
      step(1);
      check("stall_fault_drv", drv_mag, 12'h000);
      check("stall_fault_brake_n", brake_n, 1'b1);
      enable = 1'b0; step(3);
      check("stall_clear", stall, 1'b0);
`else
      torque_req = 12'h200;
      cnt = 0;
      for (int i = 0; i < 5000; i++) begin
         step(1);
         if (stall) cnt++;
      end
      check("stall_absent", cnt, 0);
      check("no_stall_drv", drv_mag, 12'h200);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
